// File: rtl/dma_timing_control_n.sv
// DMA timing-and-control engine: DREQ arbitration, HRQ/HLDA handshake and the
// SI/SO/S1-S4 single-transfer sequence over NUM_CH programmable channels.
module dma_timing_control_n #(
    parameter  int NUM_CH = 4,
    parameter  int ADDR_W = 16,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CS_N,
    input  logic              PROG_WE,
    input  logic [CH_W-1:0]   PROG_CH,
    input  logic [1:0]        PROG_SEL,
    input  logic [ADDR_W-1:0] PROG_DATA,
    input  logic              PRIO_ROT,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic              READY,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              AEN,
    output logic              ADSTB,
    output logic [ADDR_W-1:0] ADDR_OUT,
    output logic              IOR_N,
    output logic              IOW_N,
    output logic              MEMR_N,
    output logic              MEMW_N,
    output logic              EOP_N,
    output logic [NUM_CH-1:0] TC_STATUS,
    output logic [5:0]        STATE
);

    typedef enum logic [5:0] {
        ST_SI = 6'b000001,
        ST_SO = 6'b000010,
        ST_S1 = 6'b000100,
        ST_S2 = 6'b001000,
        ST_S3 = 6'b010000,
        ST_S4 = 6'b100000
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CH_W-1:0]     r_ch;
    logic [CH_W-1:0]     r_ptr;
    logic [ADDR_W-1:0]   r_addr_out;

    logic [ADDR_W-1:0]   w_addr [NUM_CH];
    logic [CNT_W-1:0]    w_cnt  [NUM_CH];
    logic [2:0]          w_mode [NUM_CH];
    logic [NUM_CH-1:0]   w_mask;
    logic [NUM_CH-1:0]   w_tc;
    logic [NUM_CH-1:0]   w_pending;
    logic [CH_W-1:0]     w_win;
    logic                w_prog_ok;
    logic                w_is_write;
    logic                w_is_read;
    logic                w_dack_en;
    logic                w_rd_phase;
    logic                w_wr_phase;

    assign w_prog_ok = PROG_WE && !CS_N && (r_state == ST_SI);
    assign w_pending = DREQ & ~w_mask;

    // Per-channel register file; programming and S4 bookkeeping never coincide
    // because programming is only accepted in SI.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ADDR_W-1:0] r_addr;
            logic [CNT_W-1:0]  r_cnt;
            logic [2:0]        r_mode;
            logic              r_mask;
            logic              r_tc;
            logic              w_hit;
            logic              w_upd;

            assign w_hit = w_prog_ok && (PROG_CH == CH_W'(gi));
            assign w_upd = (r_state == ST_S4) && (r_ch == CH_W'(gi));

            always_ff @(posedge CLK) begin
                if (!RESET_N) begin
                    r_addr <= '0;
                    r_cnt  <= '0;
                    r_mode <= '0;
                    r_mask <= 1'b1;
                    r_tc   <= 1'b0;
                end else if (w_hit) begin
                    case (PROG_SEL)
                        2'b00: r_addr <= PROG_DATA;
                        2'b01: begin
                            r_cnt <= PROG_DATA[CNT_W-1:0];
                            r_tc  <= 1'b0;
                        end
                        2'b10: r_mode <= PROG_DATA[2:0];
                        default: r_mask <= PROG_DATA[0];
                    endcase
                end else if (w_upd) begin
                    r_addr <= r_mode[2] ? (r_addr - 1'b1) : (r_addr + 1'b1);
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_tc   <= 1'b1;
                        r_mask <= 1'b1;
                    end
                end
            end

            assign w_addr[gi]    = r_addr;
            assign w_cnt[gi]     = r_cnt;
            assign w_mode[gi]    = r_mode;
            assign w_mask[gi]    = r_mask;
            assign w_tc[gi]      = r_tc;
            assign DACK[gi]      = w_dack_en && (r_ch == CH_W'(gi));
        end
    endgenerate

    // Rotating search begins one past the last serviced channel.
    always_comb begin
        int   idx;
        logic found;
        w_win = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = PRIO_ROT ? ((int'(r_ptr) + 1 + k) % NUM_CH) : k;
            if (!found && w_pending[idx]) begin
                w_win = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SI: if (|w_pending) w_state_next = ST_SO;
            ST_SO: begin
                if (HLDA)            w_state_next = ST_S1;
                else if (!DREQ[r_ch]) w_state_next = ST_SI;
            end
            ST_S1: w_state_next = ST_S2;
            ST_S2: w_state_next = ST_S3;
            ST_S3: if (READY) w_state_next = ST_S4;
            ST_S4: w_state_next = ST_SI;
            default: w_state_next = ST_SI;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= ST_SI;
            r_ch       <= '0;
            r_ptr      <= '0;
            r_addr_out <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_SI && |w_pending)
                r_ch <= w_win;
            if (r_state == ST_S4)
                r_ptr <= r_ch;
            if (w_state_next == ST_S1)
                r_addr_out <= w_addr[r_ch];
        end
    end

    assign w_is_write = (w_mode[r_ch][1:0] == 2'b01);
    assign w_is_read  = (w_mode[r_ch][1:0] == 2'b10);
    assign w_dack_en  = (r_state == ST_S2) || (r_state == ST_S3) || (r_state == ST_S4);
    assign w_rd_phase = (r_state == ST_S2) || (r_state == ST_S3);
    assign w_wr_phase = (r_state == ST_S3);

    assign HRQ       = (r_state != ST_SI);
    assign AEN       = (r_state == ST_S1) || w_dack_en;
    assign ADSTB     = (r_state == ST_S1);
    assign ADDR_OUT  = r_addr_out;
    assign IOR_N     = !(w_is_write && w_rd_phase);
    assign MEMR_N    = !(w_is_read  && w_rd_phase);
    assign MEMW_N    = !(w_is_write && w_wr_phase);
    assign IOW_N     = !(w_is_read  && w_wr_phase);
    assign EOP_N     = !((r_state == ST_S4) && (w_cnt[r_ch] == '0));
    assign TC_STATUS = w_tc;
    assign STATE     = r_state;

endmodule

// File: tb/tb_dma_timing_control_n.sv
// Scoreboard bench: stimulus queues expected transfers, a monitor pops one per S4.
`timescale 1ns/1ps
module tb_dma_timing_control_n;

    localparam int NUM_CH = 4;
    localparam logic [5:0] S_SI = 6'b000001, S_SO = 6'b000010, S_S1 = 6'b000100,
                           S_S2 = 6'b001000, S_S3 = 6'b010000, S_S4 = 6'b100000;

    logic        CLK = 0;
    logic        RESET_N, CS_N, PROG_WE, PRIO_ROT, HLDA, READY;
    logic [1:0]  PROG_CH, PROG_SEL;
    logic [15:0] PROG_DATA;
    logic [3:0]  DREQ;
    logic        HRQ, AEN, ADSTB, IOR_N, IOW_N, MEMR_N, MEMW_N, EOP_N;
    logic [3:0]  DACK, TC_STATUS;
    logic [15:0] ADDR_OUT;
    logic [5:0]  STATE;

    dma_timing_control_n #(.NUM_CH(4), .ADDR_W(16), .CNT_W(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .PROG_WE(PROG_WE),
        .PROG_CH(PROG_CH), .PROG_SEL(PROG_SEL), .PROG_DATA(PROG_DATA),
        .PRIO_ROT(PRIO_ROT), .DREQ(DREQ), .HLDA(HLDA), .READY(READY),
        .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB), .ADDR_OUT(ADDR_OUT),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N),
        .EOP_N(EOP_N), .TC_STATUS(TC_STATUS), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  ch;
        logic [15:0] addr;
        logic [3:0]  s2;     // {IOR_N,IOW_N,MEMR_N,MEMW_N} in S2
        logic [3:0]  s3;     // same, in S3
        logic        eop;
        logic [7:0]  s3n;
        logic        clean;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tx_done = 0;
    logic hlda_auto = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input int ch, input logic [15:0] a, input logic [1:0] ty,
                                input logic eop, input int s3n);
        rec_t r;
        r.ch    = ch[2:0];
        r.addr  = a;
        r.s2    = (ty == 2'b01) ? 4'b0111 : (ty == 2'b10) ? 4'b1101 : 4'b1111;
        r.s3    = (ty == 2'b01) ? 4'b0110 : (ty == 2'b10) ? 4'b1001 : 4'b1111;
        r.eop   = eop;
        r.s3n   = s3n[7:0];
        r.clean = 1'b1;
        return r;
    endfunction

    // HLDA follows HRQ one cycle late when automatic.
    initial begin
        logic h;
        HLDA = 1'b0;
        forever begin
            @(negedge CLK);
            h = HRQ;
            @(posedge CLK);
            #1 HLDA = hlda_auto & h;
        end
    end

    // Monitor: builds one record per transfer and retires it at S4.
    initial begin
        logic [15:0] cap_addr;
        logic [3:0]  cap_s2, cap_s3, cap_dack, cur;
        int          s3n;
        logic        clean;
        rec_t        act, e;
        cap_addr = '0; cap_s2 = '0; cap_s3 = '0; cap_dack = '0; s3n = 0; clean = 1'b1;
        forever begin
            @(negedge CLK);
            cur = {IOR_N, IOW_N, MEMR_N, MEMW_N};
            if (!RESET_N) begin
                s3n = 0;
                clean = 1'b1;
            end else begin
                case (STATE)
                    S_S1: begin
                        cap_addr = ADDR_OUT;
                        s3n = 0;
                        clean = 1'b1;
                        chk("s1_adstb_aen", {62'd0, ADSTB, AEN}, 64'd3);
                    end
                    S_S2: cap_s2 = cur;
                    S_S3: begin
                        if (s3n == 0) begin
                            cap_s3 = cur;
                            cap_dack = DACK;
                        end else if (cur != cap_s3 || DACK != cap_dack) begin
                            clean = 1'b0;
                        end
                        s3n++;
                    end
                    S_S4: begin
                        if (cur != 4'hF || !AEN || ADSTB || !$onehot(DACK)) clean = 1'b0;
                        act.ch = 3'd0;
                        for (int i = 0; i < NUM_CH; i++) if (DACK[i]) act.ch = i[2:0];
                        act.addr = cap_addr; act.s2 = cap_s2; act.s3 = cap_s3;
                        act.eop = EOP_N; act.s3n = s3n[7:0]; act.clean = clean;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_transfer: got ch%0d addr %0h expected none",
                                     act.ch, act.addr);
                        end else begin
                            e = exp_q.pop_front();
                            chk("transfer", 64'(act), 64'(e));
                        end
                        tx_done++;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic prog(input int ch, input int sel, input logic [15:0] data);
        @(negedge CLK);
        CS_N = 1'b0; PROG_WE = 1'b1; PROG_CH = ch[1:0]; PROG_SEL = sel[1:0]; PROG_DATA = data;
        @(negedge CLK);
        CS_N = 1'b1; PROG_WE = 1'b0;
    endtask

    task automatic prog_ch(input int ch, input logic [15:0] a, input logic [15:0] c,
                           input logic [2:0] mode);
        prog(ch, 0, a);
        prog(ch, 1, c);
        prog(ch, 2, {13'd0, mode});
        prog(ch, 3, 16'd0);
    endtask

    task automatic wait_state(input logic [5:0] st);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (STATE != st && n < 200);
        if (STATE != st) begin
            checks++;
            errors++;
            $display("FAIL wait_state: got %b expected %b", STATE, st);
        end
    endtask

    task automatic wait_tx(input int target);
        int n = 0;
        while (tx_done < target && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (tx_done < target) begin
            checks++;
            errors++;
            $display("FAIL wait_tx: got %0d expected %0d", tx_done, target);
        end
    endtask

    task automatic no_grant(input string name, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(negedge CLK);
            if (HRQ || DACK != 0) seen = 1'b1;
        end
        chk(name, {63'd0, seen}, 64'd0);
    endtask

    task automatic check_idle(input string name);
        chk(name, {STATE, HRQ, AEN, ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N, EOP_N},
                  {S_SI, 3'b000, 4'b0000, 5'b11111});
    endtask

    initial begin
        int n0;
        RESET_N = 0; CS_N = 1; PROG_WE = 0; PROG_CH = 0; PROG_SEL = 0; PROG_DATA = 0;
        PRIO_ROT = 0; DREQ = 0; READY = 1;

        // Reset state and all channels masked.
        repeat (3) @(negedge CLK);
        check_idle("reset_outputs");
        chk("reset_addr_tc", {ADDR_OUT, TC_STATUS}, 64'd0);
        RESET_N = 1;
        DREQ = 4'hF;
        no_grant("reset_masks", 8);
        DREQ = 0;

        // Write-type, count 1: two transfers, terminal count on the second.
        prog_ch(0, 16'h1000, 16'd1, 3'b001);
        exp_q.push_back(mk(0, 16'h1000, 2'b01, 1'b1, 1));
        exp_q.push_back(mk(0, 16'h1001, 2'b01, 1'b0, 1));
        DREQ = 4'b0001;
        wait_tx(2);
        no_grant("tc_automask", 20);
        chk("tc_status_set", TC_STATUS, 64'h1);
        DREQ = 0;
        prog(0, 1, 16'd5);
        chk("tc_cleared_by_count", TC_STATUS, 64'h0);

        // Fixed priority: ch1 always beats ch2.
        prog_ch(1, 16'h2000, 16'h10, 3'b000);
        prog_ch(2, 16'h3000, 16'h10, 3'b000);
        exp_q.push_back(mk(1, 16'h2000, 2'b00, 1'b1, 1));
        exp_q.push_back(mk(1, 16'h2001, 2'b00, 1'b1, 1));
        exp_q.push_back(mk(1, 16'h2002, 2'b00, 1'b1, 1));
        n0 = tx_done;
        DREQ = 4'b0110;
        wait_tx(n0 + 2);
        wait_state(S_S1);
        DREQ = 0;
        wait_tx(n0 + 3);
        repeat (3) @(negedge CLK);

        // Rotating priority from a fresh pointer: ch1, ch2, ch1.
        RESET_N = 0;
        repeat (2) @(negedge CLK);
        RESET_N = 1;
        prog_ch(1, 16'h2000, 16'h10, 3'b000);
        prog_ch(2, 16'h3000, 16'h10, 3'b000);
        PRIO_ROT = 1;
        exp_q.push_back(mk(1, 16'h2000, 2'b00, 1'b1, 1));
        exp_q.push_back(mk(2, 16'h3000, 2'b00, 1'b1, 1));
        exp_q.push_back(mk(1, 16'h2001, 2'b00, 1'b1, 1));
        n0 = tx_done;
        DREQ = 4'b0110;
        wait_tx(n0 + 2);
        wait_state(S_S1);
        DREQ = 0;
        wait_tx(n0 + 3);
        repeat (3) @(negedge CLK);

        // Read type with READY low for three S3 decisions -> four S3 cycles.
        prog_ch(3, 16'h4000, 16'd5, 3'b010);
        exp_q.push_back(mk(3, 16'h4000, 2'b10, 1'b1, 4));
        n0 = tx_done;
        READY = 0;
        DREQ = 4'b1000;
        wait_state(S_S3);
        repeat (3) @(negedge CLK);
        READY = 1;
        DREQ = 0;
        wait_tx(n0 + 1);
        repeat (3) @(negedge CLK);

        // Abort in SO; count must still be 1 afterwards.
        PRIO_ROT = 0;
        hlda_auto = 0;
        repeat (3) @(negedge CLK);
        prog_ch(0, 16'h5000, 16'd1, 3'b001);
        DREQ = 4'b0001;
        wait_state(S_SO);
        repeat (2) @(negedge CLK);
        chk("so_holds_hrq", {58'd0, STATE}, 64'(S_SO) | 64'(HRQ ^ 1'b1) << 8);
        DREQ = 0;
        @(negedge CLK);
        chk("abort_to_si", {57'd0, STATE, HRQ}, {57'd0, S_SI, 1'b0});
        no_grant("abort_no_dack", 6);
        hlda_auto = 1;
        exp_q.push_back(mk(0, 16'h5000, 2'b01, 1'b1, 1));
        exp_q.push_back(mk(0, 16'h5001, 2'b01, 1'b0, 1));
        n0 = tx_done;
        DREQ = 4'b0001;
        wait_state(S_S2);
        prog(0, 0, 16'hAAAA);
        wait_tx(n0 + 2);
        DREQ = 0;
        repeat (3) @(negedge CLK);

        // Reset in the middle of S3.
        prog(0, 1, 16'd3);
        prog(0, 3, 16'd0);
        DREQ = 4'b0001;
        wait_state(S_S3);
        RESET_N = 0;
        @(negedge CLK);
        check_idle("reset_mid_transfer");
        RESET_N = 1;
        DREQ = 4'hF;
        no_grant("reset_mid_masks", 8);
        DREQ = 0;

        // Decrement + verify: address wraps 0x0000 -> 0xFFFF, no strobes.
        prog_ch(2, 16'h0000, 16'd3, 3'b100);
        exp_q.push_back(mk(2, 16'h0000, 2'b00, 1'b1, 1));
        exp_q.push_back(mk(2, 16'hFFFF, 2'b00, 1'b1, 1));
        n0 = tx_done;
        DREQ = 4'b0100;
        wait_tx(n0 + 1);
        wait_state(S_S1);
        DREQ = 0;
        wait_tx(n0 + 2);
        repeat (3) @(negedge CLK);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dma_timing_control_n.md
Name: dma_timing_control_n

Overview:
- Parametrised DMA timing-and-control engine.
- Arbitrates NUM_CH DREQ lines, runs the HRQ/HLDA bus handshake and the SI/SO/S1–S4 transfer sequence.
- Holds per-channel current address, word count, mode and mask.
- Successor to the fixed 4-channel controller: adds configurable channel count and widths, rotating priority, READY wait states, verify and decrement modes, auto-mask on terminal count, and an exported one-hot state for SVA checkers.

Parameters:
- NUM_CH, 4, number of DMA channels (2..8).
- ADDR_W, 16, current-address width; also the PROG_DATA width.
- CNT_W, 16, word-count width; must satisfy CNT_W <= ADDR_W.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  synchronous reset, active-low.
- CS_N  in  1  chip select, active-low; programming is accepted only when low.
- PROG_WE  in  1  register write strobe.
- PROG_CH  in  $clog2(NUM_CH)  target channel.
- PROG_SEL  in  2  register select: 00 address, 01 count, 10 mode, 11 mask.
- PROG_DATA  in  ADDR_W  write data.
- PRIO_ROT  in  1  0 = fixed priority (ch0 highest), 1 = rotating priority.
- DREQ  in  NUM_CH  active-high requests.
- HLDA  in  1  hold acknowledge.
- READY  in  1  0 inserts wait states in S3.
- HRQ  out  1  hold request.
- DACK  out  NUM_CH  one-hot acknowledge.
- AEN  out  1  address enable.
- ADSTB  out  1  address strobe.
- ADDR_OUT  out  ADDR_W  current address of the serviced channel.
- IOR_N, IOW_N, MEMR_N, MEMW_N  out  1 each  active-low bus strobes.
- EOP_N  out  1  terminal-count pulse, active-low.
- TC_STATUS  out  NUM_CH  sticky terminal-count flags.
- STATE  out  6  one-hot state: SI=000001, SO=000010, S1=000100, S2=001000, S3=010000, S4=100000.

Behaviour:

Reset (RESET_N=0 at a CLK edge):
- STATE=SI; HRQ, AEN, ADSTB=0; DACK=0.
- All _N strobes=1; ADDR_OUT=0; TC_STATUS=0.
- All masks=1; address, count and mode registers=0; rotating pointer=ch0.
- Reset has priority over everything, including mid-transfer (all strobes released in the following cycle).

Programming (acts only when PROG_WE=1, CS_N=0 and STATE=SI; ignored otherwise):
- Address: the write loads the current address.
- Count: the write loads PROG_DATA[CNT_W-1:0].
- Mode: {DEC, TYPE[1:0]} = PROG_DATA[2:0]. TYPE: 00 verify, 01 write (I/O->mem), 10 read (mem->I/O), 11 treated as verify.
- Mask: mask bit = PROG_DATA[0].
- Any count write also clears TC_STATUS[PROG_CH].

Arbitration (evaluated in SI):
- Pending = DREQ & ~mask.
- Fixed priority: the lowest pending index wins.
- Rotating priority: search starts at the index after the last serviced channel.

FSM (one state per cycle unless stated):
- SI: if pending != 0, latch the winning channel, go to SO, HRQ=1.
- SO: hold HRQ.
  - If the latched DREQ drops while HLDA=0, go to SI with HRQ=0 (abort).
  - If HLDA=1, go to S1.
- S1: AEN=1, ADSTB=1 (this cycle only), ADDR_OUT=address. Go to S2.
- S2: DACK[ch]=1. Read strobe asserted: IOR_N for write type, MEMR_N for read type, none for verify. Go to S3.
- S3: read strobe held; write strobe asserted (MEMW_N for write type, IOW_N for read type).
  - If READY=0, stay in S3; strobes and DACK are held.
- S4: strobes deasserted; DACK and AEN still 1.
  - Address is ±1 according to DEC; count is decremented modulo 2^CNT_W.
  - If the count was 0 before the decrement (0 -> all-ones): EOP_N=0 for this cycle, TC_STATUS[ch]=1, mask[ch]=1.
  - Rotating pointer = ch. Go to SI.
- Leaving S4 (on the return to SI): HRQ, AEN and DACK drop.
- Single mode only: exactly one transfer per HRQ grant.

Latency and boundaries:
- Minimum DREQ-to-DACK latency: 3 cycles after HLDA.
- Minimum transfer length: SI->SI in 6 cycles with HLDA already high.
- HLDA dropping after S1 is ignored; the transfer completes.
- DREQ dropping after S1 is ignored.
- Address wraps modulo 2^ADDR_W.
- Simultaneous DREQs are resolved by the active priority scheme.
- A masked channel is never granted.
- Programming attempted outside SI is silently dropped.

Test Plan:
1. Reset, then program ch0: address 0x1000, count 1, mode 01 (write), mask 0. Hold DREQ[0]=1 with HLDA tied to HRQ delayed 1 cycle -> two transfers; ADDR_OUT 0x1000 then 0x1001; MEMW_N and IOR_N low in S3; second S4 has EOP_N=0, TC_STATUS[0]=1, mask[0]=1; no third HRQ.
2. ch1 and ch2 unmasked, both DREQs high. PRIO_ROT=0 -> ch1, ch1, ch1 serviced. PRIO_ROT=1 -> ch1, ch2, ch1 alternating.
3. Read type, READY held low 3 cycles in S3 -> STATE stays 010000 for 4 cycles; MEMR_N and IOW_N low throughout; DACK stable.
4. DREQ[0] drops in SO with HLDA=0 -> return to SI, HRQ=0, DACK never asserted, count unchanged.
5. RESET_N=0 during S3 -> next cycle STATE=000001, all strobes 1, HRQ=0, all masks=1.
6. Decrement mode with address 0x0000, verify type -> ADDR_OUT becomes 0xFFFF on the next transfer; no R/W strobes ever asserted.
